// File: rtl/mc_controller.sv
// -----------------------------------------------------------------------------
// mc_controller
//
// Multicycle ARM control unit. It steps each instruction through a Moore FSM
// (FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXECR, EXECI, ALUWB, BRANCH).
// One ALU and one memory port are shared across the cycles. The controller
// decodes data-processing, LDR/STR and B instructions. It holds the NZCV flag
// register and the conditional-execute bit, and stretches memory reads by
// MEM_LAT wait cycles.
//
// Parameters
//   MEM_LAT     extra wait cycles per memory read (0..15)
//
// Optional feature macro
//   CTRL_SHIFT_EN  when defined, cmd 1101 with I=0 (MOV/LSL) is decoded. The
//                  shifter result is selected in EXECR/ALUWB and written to Rd.
//                  When undefined, Shift stays 0 and cmd 1101 writes nothing.
//
// Ports
//   clk         in   clock, rising edge
//   reset_n     in   asynchronous active-low reset
//   Instr       in   instruction register bits [31:12]
//   ALUFlags    in   {N,Z,C,V} from the ALU in the current cycle
//   PCWrite     out  PC register enable
//   AdrSrc      out  memory address select (0=PC, 1=ALU result register)
//   MemWrite    out  data memory write strobe
//   IRWrite     out  instruction register enable
//   RegWrite    out  register file write enable
//   ResultSrc   out  result mux (00=ALUOut, 01=Data, 10=ALUResult)
//   ALUSrcA     out  ALU A select (0=RD1, 1=PC)
//   ALUSrcB     out  ALU B select (00=WriteData, 01=ExtImm, 10=4)
//   ImmSrc      out  immediate format (00=imm8, 01=imm12, 10=imm24)
//   RegSrc      out  [0]=read R15 for Rn, [1]=read Rd for Rm
//   ALUControl  out  000 ADD, 001 SUB, 010 AND, 011 ORR, 100 EOR, 101 ADC
//   carry       out  registered C flag, used as the ALU carry-in
//   Shift       out  select the shifter output as the ALU result
// -----------------------------------------------------------------------------
module mc_controller #(
    parameter int MEM_LAT = 0
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic [31:12] Instr,
    input  logic [3:0]   ALUFlags,
    output logic         PCWrite,
    output logic         AdrSrc,
    output logic         MemWrite,
    output logic         IRWrite,
    output logic         RegWrite,
    output logic [1:0]   ResultSrc,
    output logic         ALUSrcA,
    output logic [1:0]   ALUSrcB,
    output logic [1:0]   ImmSrc,
    output logic [1:0]   RegSrc,
    output logic [2:0]   ALUControl,
    output logic         carry,
    output logic         Shift
);

    typedef enum logic [3:0] {
        FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXECR, EXECI, ALUWB, BRANCH
    } state_t;

    localparam logic [3:0] LAT = 4'(MEM_LAT);

    state_t     state_reg;
    logic [3:0] wait_cnt_reg;
    logic [3:0] flags_reg;      // {N,Z,C,V}
    logic       cond_ex_reg;

    // Instruction fields
    logic [3:0] cond;
    logic [1:0] op;
    logic       imm_bit;
    logic [3:0] cmd;
    logic       s_bit;
    logic       rd_is_pc;

    assign cond     = Instr[31:28];
    assign op       = Instr[27:26];
    assign imm_bit  = Instr[25];
    assign cmd      = Instr[24:21];
    assign s_bit    = Instr[20];          // also the L bit of LDR/STR
    assign rd_is_pc = (Instr[15:12] == 4'hF);

    // The Rn field only steers the register file, never the controller.
    logic unused_rn;
    assign unused_rn = ^Instr[19:16];

    // The counter counts up from 0, so a reset value of 0 gives the first
    // IRWrite in cycle MEM_LAT.
    logic wait_done;
    assign wait_done = (wait_cnt_reg == LAT);

    // ------------------------------------------------------------------
    // Data-processing command decode
    // ------------------------------------------------------------------
    logic       dp_valid;
    logic       no_write;
    logic       cv_write;
    logic       is_mov;
    logic [2:0] alu_op;

    always_comb begin
        dp_valid = 1'b1;
        no_write = 1'b0;
        cv_write = 1'b0;
        is_mov   = 1'b0;
        alu_op   = 3'b000;
        case (cmd)
            4'b0100: begin alu_op = 3'b000; cv_write = 1'b1; end  // ADD
            4'b0010: begin alu_op = 3'b001; cv_write = 1'b1; end  // SUB
            4'b0000: alu_op = 3'b010;                             // AND
            4'b1100: alu_op = 3'b011;                             // ORR
            4'b0001: alu_op = 3'b100;                             // EOR
            4'b0101: begin alu_op = 3'b101; cv_write = 1'b1; end  // ADC
            4'b1010: begin                                        // CMP
                alu_op   = 3'b001;
                cv_write = 1'b1;
                no_write = 1'b1;
            end
`ifdef CTRL_SHIFT_EN
            4'b1101: begin                                        // MOV/LSL
                // Only the register form goes through the shifter.
                dp_valid = ~imm_bit;
                is_mov   = ~imm_bit;
            end
`endif
            default: dp_valid = 1'b0;
        endcase
    end

    logic flag_w;
    logic dp_write;
    assign flag_w   = s_bit & dp_valid;
    assign dp_write = cond_ex_reg & dp_valid & ~no_write;

    // ------------------------------------------------------------------
    // Condition check against the current flag register
    // ------------------------------------------------------------------
    logic cond_pass;
    logic fn, fz, fc, fv;
    assign {fn, fz, fc, fv} = flags_reg;

    always_comb begin
        cond_pass = 1'b0;
        case (cond)
            4'b0000: cond_pass = fz;                     // EQ
            4'b0001: cond_pass = ~fz;                    // NE
            4'b0010: cond_pass = fc;                     // CS
            4'b0011: cond_pass = ~fc;                    // CC
            4'b0100: cond_pass = fn;                     // MI
            4'b0101: cond_pass = ~fn;                    // PL
            4'b0110: cond_pass = fv;                     // VS
            4'b0111: cond_pass = ~fv;                    // VC
            4'b1000: cond_pass = fc & ~fz;               // HI
            4'b1001: cond_pass = ~fc | fz;               // LS
            4'b1010: cond_pass = (fn == fv);             // GE
            4'b1011: cond_pass = (fn != fv);             // LT
            4'b1100: cond_pass = ~fz & (fn == fv);       // GT
            4'b1101: cond_pass = fz | (fn != fv);        // LE
            4'b1110: cond_pass = 1'b1;                   // AL
            default: cond_pass = 1'b0;                   // never
        endcase
    end

    // ------------------------------------------------------------------
    // State, wait counter, flags and conditional-execute bit
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg    <= FETCH;
            wait_cnt_reg <= 4'd0;
            flags_reg    <= 4'b0000;
            cond_ex_reg  <= 1'b0;
        end else begin
            case (state_reg)
                FETCH: begin
                    if (wait_done) begin
                        state_reg <= DECODE;
                    end else begin
                        wait_cnt_reg <= wait_cnt_reg + 4'd1;
                    end
                end
                DECODE: begin
                    cond_ex_reg <= cond_pass;
                    case (op)
                        2'b01: state_reg <= MEMADR;
                        2'b10: state_reg <= BRANCH;
                        2'b00: state_reg <= imm_bit ? EXECI : EXECR;
                        default: begin
                            state_reg    <= FETCH;
                            wait_cnt_reg <= 4'd0;
                        end
                    endcase
                end
                MEMADR: begin
                    if (s_bit) begin
                        state_reg    <= MEMRD;
                        wait_cnt_reg <= 4'd0;
                    end else begin
                        state_reg <= MEMWR;
                    end
                end
                MEMRD: begin
                    if (wait_done) begin
                        state_reg <= MEMWB;
                    end else begin
                        wait_cnt_reg <= wait_cnt_reg + 4'd1;
                    end
                end
                EXECR, EXECI: begin
                    state_reg <= ALUWB;
                    // NZ always follow the ALU; CV only for arithmetic ops.
                    if (cond_ex_reg && flag_w) begin
                        flags_reg[3:2] <= ALUFlags[3:2];
                        if (cv_write) begin
                            flags_reg[1:0] <= ALUFlags[1:0];
                        end
                    end
                end
                default: begin  // MEMWB, MEMWR, ALUWB, BRANCH
                    state_reg    <= FETCH;
                    wait_cnt_reg <= 4'd0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Output decode from the registered state and Instr
    // ------------------------------------------------------------------
    logic pc_write_dec;
    logic ir_write_dec;
    logic mem_write_dec;
    logic reg_write_dec;
    logic shift_dec;

    always_comb begin
        pc_write_dec  = 1'b0;
        ir_write_dec  = 1'b0;
        mem_write_dec = 1'b0;
        reg_write_dec = 1'b0;
        shift_dec     = 1'b0;
        AdrSrc        = 1'b0;
        ResultSrc     = 2'b00;
        ALUSrcA       = 1'b0;
        ALUSrcB       = 2'b00;
        ImmSrc        = 2'b00;
        ALUControl    = 3'b000;
        case (state_reg)
            FETCH: begin
                ALUSrcA   = 1'b1;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
                if (wait_done) begin
                    ir_write_dec = 1'b1;
                    pc_write_dec = 1'b1;
                end
            end
            DECODE: begin
                // PC+4 again, so R15 reads as PC+8.
                ALUSrcA   = 1'b1;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
            end
            MEMADR: begin
                ALUSrcB = 2'b01;
                ImmSrc  = 2'b01;
            end
            MEMRD: AdrSrc = 1'b1;
            MEMWB: begin
                ResultSrc     = 2'b01;
                reg_write_dec = cond_ex_reg;
                pc_write_dec  = cond_ex_reg & rd_is_pc;
            end
            MEMWR: begin
                AdrSrc        = 1'b1;
                mem_write_dec = cond_ex_reg;
            end
            EXECR: begin
                ALUSrcB    = 2'b00;
                ALUControl = alu_op;
                shift_dec  = is_mov;
            end
            EXECI: begin
                ALUSrcB    = 2'b01;
                ImmSrc     = 2'b00;
                ALUControl = alu_op;
            end
            ALUWB: begin
                ResultSrc     = 2'b00;
                reg_write_dec = dp_write;
                pc_write_dec  = dp_write & rd_is_pc;
                shift_dec     = is_mov;
            end
            BRANCH: begin
                ALUSrcB      = 2'b01;
                ImmSrc       = 2'b10;
                ResultSrc    = 2'b10;
                pc_write_dec = cond_ex_reg;
            end
            default: ;
        endcase
    end

    // Enables are forced low for as long as reset is held, including any
    // write that was in progress when reset arrived.
    assign PCWrite  = reset_n & pc_write_dec;
    assign IRWrite  = reset_n & ir_write_dec;
    assign MemWrite = reset_n & mem_write_dec;
    assign RegWrite = reset_n & reg_write_dec;

    assign Shift    = shift_dec;
    assign RegSrc   = {(op == 2'b01) & ~s_bit, (op == 2'b10)};
    assign carry    = flags_reg[1];

endmodule

// File: tb/tb_mc_controller.sv
// -----------------------------------------------------------------------------
// tb_mc_controller
//
// Directed bench for mc_controller. Instance "a" uses MEM_LAT=0 and runs a
// sequence of data-processing, branch, compare, store and reset steps.
// Instance "b" uses MEM_LAT=2 and runs an LDR, which is checked cycle by cycle.
// -----------------------------------------------------------------------------
module tb_mc_controller;

    logic clk = 1'b0;
    always #5 clk = ~clk;

`ifdef CTRL_SHIFT_EN
    localparam logic SH = 1'b1;
`else
    localparam logic SH = 1'b0;
`endif

    int checks = 0;
    int errors = 0;

    // Instance a: MEM_LAT = 0
    logic         rst_a;
    logic [31:12] instr_a;
    logic [3:0]   flags_a;
    logic         pcw_a, adrsrc_a, memw_a, irw_a, regw_a, srca_a, carry_a, shift_a;
    logic [1:0]   ressrc_a, srcb_a, immsrc_a, regsrc_a;
    logic [2:0]   aluctl_a;

    // Instance b: MEM_LAT = 2
    logic         rst_b;
    logic [31:12] instr_b;
    logic [3:0]   flags_b;
    logic         pcw_b, adrsrc_b, memw_b, irw_b, regw_b, srca_b, carry_b, shift_b;
    logic [1:0]   ressrc_b, srcb_b, immsrc_b, regsrc_b;
    logic [2:0]   aluctl_b;

    mc_controller #(.MEM_LAT(0)) dut_a (
        .clk(clk), .reset_n(rst_a), .Instr(instr_a), .ALUFlags(flags_a),
        .PCWrite(pcw_a), .AdrSrc(adrsrc_a), .MemWrite(memw_a), .IRWrite(irw_a),
        .RegWrite(regw_a), .ResultSrc(ressrc_a), .ALUSrcA(srca_a), .ALUSrcB(srcb_a),
        .ImmSrc(immsrc_a), .RegSrc(regsrc_a), .ALUControl(aluctl_a),
        .carry(carry_a), .Shift(shift_a)
    );

    mc_controller #(.MEM_LAT(2)) dut_b (
        .clk(clk), .reset_n(rst_b), .Instr(instr_b), .ALUFlags(flags_b),
        .PCWrite(pcw_b), .AdrSrc(adrsrc_b), .MemWrite(memw_b), .IRWrite(irw_b),
        .RegWrite(regw_b), .ResultSrc(ressrc_b), .ALUSrcA(srca_b), .ALUSrcB(srcb_b),
        .ImmSrc(immsrc_b), .RegSrc(regsrc_b), .ALUControl(aluctl_b),
        .carry(carry_b), .Shift(shift_b)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic load_a(input logic [31:0] w);
        instr_a = w[31:12];
        $display("a: instr %08h", w);
    endtask

    task automatic load_b(input logic [31:0] w);
        instr_b = w[31:12];
        $display("b: instr %08h", w);
    endtask

    logic [11:0] exp_irw;
    logic [11:0] exp_regw;
    logic [11:0] exp_adr;

    initial begin
        rst_a   = 1'b0;
        rst_b   = 1'b0;
        instr_a = '0;
        instr_b = '0;
        flags_a = 4'b0000;
        flags_b = 4'b0000;
        repeat (2) tick();

        // Held in reset: all enables low
        chk("rst_irw", irw_a, 0);
        chk("rst_pcw", pcw_a, 0);
        chk("rst_carry", carry_a, 0);

        // ADDS R1,R2,#1 with ALUFlags Z=1
        load_a(32'hE2921001);
        flags_a = 4'b0100;
        rst_a = 1'b1;
        #1;
        chk("adds_c0_irw", irw_a, 1);
        chk("adds_c0_pcw", pcw_a, 1);
        chk("adds_c0_srca", srca_a, 1);
        chk("adds_c0_srcb", srcb_a, 2);
        tick();
        chk("adds_c1_irw", irw_a, 0);
        chk("adds_c1_ressrc", ressrc_a, 2);
        tick();
        chk("adds_c2_srcb", srcb_a, 1);
        chk("adds_c2_immsrc", immsrc_a, 0);
        chk("adds_c2_aluctl", aluctl_a, 0);
        chk("adds_c2_regw", regw_a, 0);
        tick();
        chk("adds_c3_regw", regw_a, 1);
        chk("adds_c3_ressrc", ressrc_a, 0);
        chk("adds_c3_pcw", pcw_a, 0);
        tick();
        chk("adds_c4_irw", irw_a, 1);

        // BNE with Z=1: not taken
        load_a(32'h1A000002);
        flags_a = 4'b0000;
        tick();
        tick();
        chk("bne_pcw", pcw_a, 0);
        chk("bne_srcb", srcb_a, 1);
        chk("bne_immsrc", immsrc_a, 2);
        chk("bne_regsrc", regsrc_a, 1);
        tick();
        chk("bne_next_irw", irw_a, 1);

        // BEQ with Z=1: taken
        load_a(32'h0A000002);
        tick();
        tick();
        chk("beq_pcw", pcw_a, 1);
        chk("beq_ressrc", ressrc_a, 2);
        tick();

        // CMP R0,R0 with ALUFlags 0110
        load_a(32'hE1500000);
        flags_a = 4'b0110;
        tick();
        tick();
        chk("cmp_srcb", srcb_a, 0);
        chk("cmp_aluctl", aluctl_a, 1);
        chk("cmp_exec_regw", regw_a, 0);
        tick();
        chk("cmp_wb_regw", regw_a, 0);
        chk("cmp_carry", carry_a, 1);
        tick();

        // ADDEQ R1,R2,#1 (no S): Z=1 so it writes, flags unchanged
        load_a(32'h02821001);
        flags_a = 4'b0000;
        tick();
        tick();
        tick();
        chk("addeq_regw", regw_a, 1);
        chk("addeq_carry", carry_a, 1);
        tick();

        // ADDNE R1,R2,#1: Z=1 so no write
        load_a(32'h12821001);
        tick();
        tick();
        tick();
        chk("addne_regw", regw_a, 0);
        tick();

        // ADD PC,PC,#4: Rd=15 also writes the PC
        load_a(32'hE28FF004);
        tick();
        tick();
        tick();
        chk("addpc_regw", regw_a, 1);
        chk("addpc_pcw", pcw_a, 1);
        tick();

        // MOV R0,R1,LSL#2
        load_a(32'hE1A00101);
        tick();
        tick();
        chk("mov_exec_shift", shift_a, SH);
        tick();
        chk("mov_wb_shift", shift_a, SH);
        chk("mov_wb_regw", regw_a, SH);
        tick();

        // op=11: straight back to FETCH
        load_a(32'hEC000000);
        tick();
        chk("op11_dec_irw", irw_a, 0);
        tick();
        chk("op11_fetch_irw", irw_a, 1);

        // STR R1,[R2,#4], then reset in the middle of MEMWR
        load_a(32'hE5821004);
        tick();
        tick();
        chk("str_adr_srcb", srcb_a, 1);
        chk("str_adr_immsrc", immsrc_a, 1);
        chk("str_adr_regsrc", regsrc_a, 2);
        tick();
        chk("str_wr_memw", memw_a, 1);
        chk("str_wr_adrsrc", adrsrc_a, 1);
        rst_a = 1'b0;
        #1;
        chk("str_rst_memw", memw_a, 0);
        chk("str_rst_carry", carry_a, 0);
        tick();
        tick();
        rst_a = 1'b1;
        #1;
        chk("rel_c0_irw", irw_a, 1);
        chk("rel_c0_memw", memw_a, 0);
        tick();
        chk("rel_c1_irw", irw_a, 0);
        $display("a: reset release done");

        // MEM_LAT=2: LDR R1,[R2,#4], checked over cycles 0..11
        load_b(32'hE5921004);
        exp_irw  = 12'b1000_0000_0100;
        exp_regw = 12'b0001_0000_0000;
        exp_adr  = 12'b0000_1110_0000;
        rst_b = 1'b1;
        #1;
        for (int c = 0; c < 12; c++) begin
            chk($sformatf("ldr_c%0d_irw", c), irw_b, exp_irw[c]);
            chk($sformatf("ldr_c%0d_regw", c), regw_b, exp_regw[c]);
            chk($sformatf("ldr_c%0d_adrsrc", c), adrsrc_b, exp_adr[c]);
            if (c == 8) begin
                chk("ldr_c8_ressrc", ressrc_b, 1);
            end
            if (c == 4) begin
                chk("ldr_c4_immsrc", immsrc_b, 1);
            end
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
